// File: rtl/stream_counter.sv
// Stochastic-to-binary readout: counts the ones on each bitstream lane over a
// fixed window of WINDOW cycles and presents the per-lane sums with a valid pulse.
module stream_counter #(
    parameter int LANES  = 8,
    parameter int WINDOW = 256,
    parameter int CW     = $clog2(WINDOW + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LANES-1:0]      stream_in,
    output logic                  busy,
    output logic [LANES*CW-1:0]   count_out,
    output logic                  valid
);

    localparam int WW = $clog2(WINDOW);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [WW-1:0]           win_q, win_d;
    logic [CW-1:0]           acc_q [LANES];
    logic [CW-1:0]           acc_d [LANES];
    logic [LANES*CW-1:0]     count_q, count_d;
    logic                    valid_q, valid_d;

    // Handshake: a start seen at a rising edge while idle opens a window; the
    // result is held on count_out and flagged by valid for exactly one cycle.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        count_d = count_q;
        valid_d = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            acc_d[i] = acc_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COUNT;
                    win_d   = '0;
                    for (int i = 0; i < LANES; i++) begin
                        acc_d[i] = '0;
                    end
                end
            end
            ST_COUNT: begin
                win_d = win_q + 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    acc_d[i] = acc_q[i] + CW'(stream_in[i]);
                end
                // The last sample is folded straight into the published sums.
                if (win_q == WIN_LAST) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b1;
                    for (int i = 0; i < LANES; i++) begin
                        count_d[i*CW +: CW] = acc_d[i];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            count_q <= count_d;
            valid_q <= valid_d;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign busy      = (state_q == ST_COUNT);
    assign count_out = count_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_stream_counter.sv
// Bench for stream_counter (WINDOW=16): directed and random windows checked
// against a history-based model that sums recorded input over each window.
module tb_stream_counter;

    localparam int L  = 8;
    localparam int W  = 16;
    localparam int CW = 5;
    localparam int HN = 1024;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [L-1:0]    stream_in = '0;
    logic            busy;
    logic [L*CW-1:0] count_out;
    logic            valid;

    int vectors = 0;
    int miscompares = 0;

    // model state
    int              cyc = 0;
    logic [L-1:0]    hist [HN];
    bit              active = 0;
    int              ws = 0;
    logic [L*CW-1:0] exp_count = '0;

    stream_counter #(.LANES(L), .WINDOW(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stream_in (stream_in),
        .busy      (busy),
        .count_out (count_out),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [L*CW-1:0] window_sums(input int first);
        logic [L*CW-1:0] r;
        int s;
        r = '0;
        for (int ln = 0; ln < L; ln++) begin
            s = 0;
            for (int t = first; t < first + W; t++) begin
                s += int'(hist[t % HN][ln]);
            end
            r[ln*CW +: CW] = CW'(s);
        end
        return r;
    endfunction

    task automatic check_outputs(input string tag, input bit eb, input bit ev,
                                 input logic [L*CW-1:0] ec);
        vectors++;
        assert (busy === eb) else begin
            miscompares++;
            $error("FAIL %s.busy cyc=%0d observed=%0b expected=%0b", tag, cyc, busy, eb);
        end
        vectors++;
        assert (valid === ev) else begin
            miscompares++;
            $error("FAIL %s.valid cyc=%0d observed=%0b expected=%0b", tag, cyc, valid, ev);
        end
        vectors++;
        assert (count_out === ec) else begin
            miscompares++;
            $error("FAIL %s.count cyc=%0d observed=%h expected=%h", tag, cyc, count_out, ec);
        end
    endtask

    // One clock cycle: check the registered outputs, then drive this cycle's inputs.
    task automatic tick(input string tag, input bit st, input logic [L-1:0] si);
        bit eb, ev;
        @(negedge clk);
        cyc++;
        eb = active && (cyc >= ws + 1) && (cyc <= ws + W);
        ev = active && (cyc == ws + W + 1);
        if (ev) exp_count = window_sums(ws + 1);
        check_outputs(tag, eb, ev, exp_count);
        start = st;
        stream_in = si;
        hist[cyc % HN] = si;
        if (st && !eb) begin
            active = 1;
            ws = cyc;
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        stream_in = '0;
        active = 0;
        exp_count = '0;
        #1;
        check_outputs(tag, 1'b0, 1'b0, '0);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) tick(tag, 1'b0, '0);
    endtask

    initial begin
        // reset then idle
        pulse_reset("rst");
        idle("idle", 40);

        // full and empty lanes
        tick("full", 1'b1, 8'hF0);
        for (int k = 0; k < W; k++) tick("full", 1'b0, 8'hF0);
        idle("full", 3);

        // ones only outside the window
        tick("edge0", 1'b1, 8'h01);
        for (int k = 0; k < W; k++) tick("edge0", 1'b0, 8'h00);
        tick("edge0", 1'b0, 8'h01);
        idle("edge0", 2);

        // ones on first and last sample
        tick("edge2", 1'b1, 8'h00);
        tick("edge2", 1'b0, 8'h01);
        for (int k = 0; k < W - 2; k++) tick("edge2", 1'b0, 8'h00);
        tick("edge2", 1'b0, 8'h01);
        idle("edge2", 2);

        // lane2 every 4th sample, lane5 alternate samples
        tick("prob", 1'b1, 8'h00);
        for (int k = 0; k < W; k++) begin
            logic [L-1:0] v;
            v = '0;
            v[2] = (k % 4 == 0);
            v[5] = (k % 2 == 0);
            tick("prob", 1'b0, v);
        end
        idle("prob", 2);

        // start while busy ignored, then back-to-back in the valid cycle
        tick("b2b", 1'b1, L'($urandom));
        for (int k = 1; k <= W; k++) tick("b2b", k == 5, L'($urandom));
        tick("b2b", 1'b1, L'($urandom));
        for (int k = 0; k < W; k++) tick("b2b", k == 3, L'($urandom));
        idle("b2b", 3);

        // reset mid-window, then a fresh window
        tick("rmid", 1'b1, L'($urandom));
        for (int k = 1; k < 8; k++) tick("rmid", 1'b0, L'($urandom));
        pulse_reset("rmid_rst");
        idle("rmid", 20);
        tick("fresh", 1'b1, L'($urandom));
        for (int k = 0; k < W; k++) tick("fresh", 1'b0, L'($urandom));
        idle("fresh", 2);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            tick("rand", $urandom_range(0, 3) == 0, L'($urandom));
        end
        idle("rand", W + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
